extra_sum_accum: RTL

Upstream producer stage for the mode-gated result register. It accepts a valid/ready stream of unsigned samples and sums each group of BEATS samples, or fewer if in_last ends the group early. For each completed group it emits the sum on sum_out together with a one-cycle sum_valid pulse. sum_out and sum_valid connect directly to the downstream register's extra_sum and mode inputs. The downstream register applies no backpressure, so sum_valid is a pulse, not a handshake.

---
 rtl/extra_sum_pkg.sv | 14 +
 rtl/extra_sum_add.sv | 23 ++
 rtl/extra_sum_accum.sv | 117 +++++++++++
 3 files changed

// File: rtl/extra_sum_pkg.sv
// Shared types for the grouped-sample summing stage (extra_sum_accum).
package extra_sum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } accum_state_e;

  // Beat counter is sized for the largest legal group so any BEATS override fits.
  localparam int BEATS_MAX = 255;
  localparam int CNT_W     = $clog2(BEATS_MAX + 1);

endpackage

// File: rtl/extra_sum_add.sv
// Combinational WIDTH-bit adder returning sum and carry-out.
// With SATURATE_EN defined the sum clamps to all-ones on carry; otherwise it wraps.
module extra_sum_add #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  logic [WIDTH:0] full;

  assign full  = {1'b0, a} + {1'b0, b};
  assign carry = full[WIDTH];

`ifdef SATURATE_EN
  assign sum = carry ? {WIDTH{1'b1}} : full[WIDTH-1:0];
`else
  assign sum = full[WIDTH-1:0];
`endif

endmodule

// File: rtl/extra_sum_accum.sv
// Sums valid/ready sample groups of up to BEATS beats and emits a one-cycle sum_valid pulse.
// Optional macro SATURATE_EN makes the accumulator saturate instead of wrapping.
module extra_sum_accum
  import extra_sum_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BEATS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             sum_valid,
  output logic [WIDTH-1:0] sum_out,
  output logic             sum_ovf
);

  accum_state_e     state, state_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             ovf, ovf_nxt;

  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_sum;
  logic             add_carry;
  logic             take;

  assign in_ready = (state != EMIT);
  assign take     = in_valid && in_ready && !clr;

  // Starting a group adds onto zero, so IDLE and ACCUM share one adder path.
  assign add_a = (state == IDLE) ? '0 : acc;

  extra_sum_add #(
    .WIDTH (WIDTH)
  ) u_add (
    .a     (add_a),
    .b     (in_data),
    .sum   (add_sum),
    .carry (add_carry)
  );

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf;
    unique case (state)
      IDLE, ACCUM: begin
        if (clr) begin
          state_nxt = IDLE;
          acc_nxt   = '0;
          cnt_nxt   = '0;
          ovf_nxt   = 1'b0;
        end else if (take) begin
          acc_nxt = add_sum;
          cnt_nxt = (state == IDLE) ? CNT_W'(1) : cnt + CNT_W'(1);
          ovf_nxt = (state == IDLE) ? 1'b0 : (ovf | add_carry);
          if (in_last || (cnt_nxt == CNT_W'(BEATS)))
            state_nxt = EMIT;
          else
            state_nxt = ACCUM;
        end
      end
      EMIT: begin
        state_nxt = IDLE;
        acc_nxt   = '0;
        cnt_nxt   = '0;
        ovf_nxt   = 1'b0;
      end
      default: begin
        state_nxt = IDLE;
        acc_nxt   = '0;
        cnt_nxt   = '0;
        ovf_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      ovf   <= ovf_nxt;
    end
  end

  // Output register: sum_out/sum_ovf hold between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_valid <= 1'b0;
      sum_out   <= '0;
      sum_ovf   <= 1'b0;
    end else begin
      sum_valid <= (state == EMIT);
      if (state == EMIT) begin
        sum_out <= acc;
        sum_ovf <= ovf;
      end
    end
  end

  a_pulse_single: assert property (@(posedge clk) disable iff (!rst_n)
    sum_valid |=> !sum_valid);
  a_emit_one_cycle: assert property (@(posedge clk) disable iff (!rst_n)
    (state == EMIT) |=> (state == IDLE));

endmodule
